adc_read_sequencer: RTL

- Sequences XADC DRP reads of the aux-channel result register after each end-of-conversion.
- Discards samples taken while a servo is stepping, then averages 2^AVG_LOG2 settled samples.
- Emits one filtered 12-bit sample with a one-cycle valid strobe.
- Sits between the xadc instance and the voltage_comparator/FF_Array/LCD consumers, in the pll_clk domain.

---
 rtl/sp_pkg.sv | 23 ++
 rtl/adc_read_sequencer_if.sv | 15 +
 rtl/adc_read_sequencer_accum.sv | 55 +++++
 rtl/adc_read_sequencer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/sp_pkg.sv
// Shared constants for the ADC read sequencer: state encoding, sample width
// and the position of the 12-bit result within the XADC DO word.
package sp_pkg;

  localparam int ADC_W   = 12;
  localparam int ADC_MSB = 15;
  localparam int ADC_LSB = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ACCUM = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_ACCUM = ST_ACCUM,
    S_EMIT  = ST_EMIT
  } state_t;

endpackage

// File: rtl/adc_read_sequencer_if.sv
// XADC DRP-side signals: conversion strobe, read handshake and result word.
// The sequencer is the DRP master; the XADC instance is the slave.
interface adc_read_sequencer_if;
  import sp_pkg::*;

  logic             EOC;
  logic             DRDY;
  logic [ADC_MSB:0] DO;
  logic             DEN;
  logic [6:0]       DADDR;

  modport master (input EOC, input DRDY, input DO, output DEN, output DADDR);
  modport slave  (output EOC, output DRDY, output DO, input DEN, input DADDR);

endinterface

// File: rtl/adc_read_sequencer_accum.sv
// Averaging datapath: accumulates settled samples and emits the truncated
// mean with a one-cycle valid strobe; last flags that the next add completes a set.
module adc_read_sequencer_accum
  import sp_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             add,
  input  logic             emit,
  input  logic [ADC_W-1:0] din,
  output logic             last,
  output logic [ADC_W-1:0] sample,
  output logic             sample_vld
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [ADC_W-1:0] sample_reg;
  logic             vld_reg;

  assign last       = (cnt_reg == CNT_LAST);
  assign sample     = sample_reg;
  assign sample_vld = vld_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_reg    <= '0;
      cnt_reg    <= '0;
      sample_reg <= '0;
      vld_reg    <= 1'b0;
    end else begin
      vld_reg <= 1'b0;
      if (emit) begin
        sample_reg <= ADC_W'(acc_reg >> AVG_LOG2);
        vld_reg    <= 1'b1;
        acc_reg    <= '0;
        cnt_reg    <= '0;
      end else if (clr) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else if (add) begin
        acc_reg <= acc_reg + ACC_W'(din);
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/adc_read_sequencer.sv
// Reads the XADC aux result over DRP after each EOC, drops unsettled samples
// around servo steps and averages the rest. ADC_PEAK_HOLD_EN adds a peak tracker.
module adc_read_sequencer
  import sp_pkg::*;
#(
  parameter logic [6:0] DRP_ADDR       = 7'h10,
  parameter int         AVG_LOG2       = 2,
  parameter int         SETTLE_DISCARD = 3,
  parameter int         DRDY_TIMEOUT   = 64
) (
  input  logic                        CLK,
  input  logic                        RST,
  adc_read_sequencer_if.master        drp,
  input  logic                        HOLD,
  output logic [ADC_W-1:0]            SAMPLE,
  output logic                        SAMPLE_VLD,
  output logic                        BUSY,
  output logic                        ERR
`ifdef ADC_PEAK_HOLD_EN
  ,
  output logic [ADC_W-1:0]            PEAK,
  input  logic                        PEAK_CLR
`endif
);

  localparam int TO_W = $clog2(DRDY_TIMEOUT);
  localparam logic [TO_W-1:0] TO_INIT   = TO_W'(DRDY_TIMEOUT - 1);
  localparam logic [3:0]      DISC_INIT = 4'(SETTLE_DISCARD);

  state_t           state_reg, state_next;
  logic [TO_W-1:0]  to_reg, to_next;
  logic [3:0]       disc_reg, disc_next;
  logic             err_reg, err_next;
  logic [ADC_W-1:0] data_reg, data_next;
  logic             acc_clr, acc_add, acc_emit, acc_last;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_IDLE;
      to_reg    <= '0;
      disc_reg  <= DISC_INIT;
      err_reg   <= 1'b0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      to_reg    <= to_next;
      disc_reg  <= disc_next;
      err_reg   <= err_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    to_next    = to_reg;
    disc_next  = disc_reg;
    err_next   = err_reg;
    data_next  = data_reg;
    acc_clr    = 1'b0;
    acc_add    = 1'b0;
    acc_emit   = 1'b0;
    unique case (state_reg)
      S_IDLE: if (drp.EOC) state_next = S_ISSUE;
      S_ISSUE: begin
        to_next    = TO_INIT;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (drp.DRDY) begin
          data_next  = drp.DO[ADC_MSB:ADC_LSB];
          state_next = S_ACCUM;
        end else if (to_reg == '0) begin
          // Abandon the set: a partial average across a lost read would skew the mean.
          err_next   = 1'b1;
          acc_clr    = 1'b1;
          state_next = S_IDLE;
        end else begin
          to_next = to_reg - TO_W'(1);
        end
      end
      S_ACCUM: begin
        state_next = S_IDLE;
        if (HOLD) begin
          disc_next = DISC_INIT;
          acc_clr   = 1'b1;
        end else if (disc_reg != 4'd0) begin
          disc_next = disc_reg - 4'd1;
        end else begin
          acc_add = 1'b1;
          if (acc_last) state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        acc_emit   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign drp.DEN   = (state_reg == S_ISSUE);
  assign drp.DADDR = DRP_ADDR;
  assign BUSY      = (state_reg != S_IDLE);
  assign ERR       = err_reg;

  adc_read_sequencer_accum #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk        (CLK),
    .srst       (RST),
    .clr        (acc_clr),
    .add        (acc_add),
    .emit       (acc_emit),
    .din        (data_reg),
    .last       (acc_last),
    .sample     (SAMPLE),
    .sample_vld (SAMPLE_VLD)
  );

`ifdef ADC_PEAK_HOLD_EN
  logic [ADC_W-1:0] peak_reg;

  // Tracks the registered SAMPLE, so a clear during the strobe restarts from that sample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      peak_reg <= '0;
    end else if (PEAK_CLR) begin
      peak_reg <= SAMPLE_VLD ? SAMPLE : '0;
    end else if (SAMPLE_VLD && (SAMPLE > peak_reg)) begin
      peak_reg <= SAMPLE;
    end
  end

  assign PEAK = peak_reg;
`endif

endmodule
